// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder with a byte-wide internal memory.
// It handles one transaction at a time through a single FSM.
package axi_lite_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WADDR,
        WDATA,
        WRESP
    } state_type;
endpackage

module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_W,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int BUFFER_SIZE = 4096
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_valid,
    input  logic                  r_ready,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [STRB_WIDTH-1:0] w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready
);

    localparam int IDX_W = $clog2(BUFFER_SIZE);
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(BUFFER_SIZE);

    state_type state;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

    logic rd_ok;
    logic wr_ok;
    logic w_fire;

    assign rd_ok  = {1'b0, ar_addr} < LIMIT;
    assign wr_ok  = {1'b0, addr_q} < LIMIT;
    assign w_fire = (state == WDATA) && w_valid && w_ready;

    // Memory has no reset; w_ready is forced low in reset, so no write can land.
    always_ff @(posedge aclk) begin
        if (w_fire && wr_ok && w_strb[0]) begin
            mem[addr_q[IDX_W-1:0]] <= w_data;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_resp   <= RESP_OKAY;
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
            b_resp   <= RESP_OKAY;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ar_valid) begin
                        ar_ready <= 1'b1;
                        state    <= RADDR;
                    end else if (aw_valid) begin
                        aw_ready <= 1'b1;
                        state    <= WADDR;
                    end
                end
                RADDR: begin
                    ar_ready <= 1'b0;
                    addr_q   <= ar_addr;
                    r_valid  <= 1'b1;
                    r_resp   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_data   <= rd_ok ? mem[ar_addr[IDX_W-1:0]] : '0;
                    state    <= RDATA;
                end
                RDATA: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                WADDR: begin
                    aw_ready <= 1'b0;
                    addr_q   <= aw_addr;
                    w_ready  <= 1'b1;
                    state    <= WDATA;
                end
                WDATA: begin
                    if (w_valid) begin
                        w_ready <= 1'b0;
                        b_valid <= 1'b1;
                        b_resp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                        state   <= WRESP;
                    end
                end
                WRESP: begin
                    if (b_ready) begin
                        b_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_lite_mem_slave.md
# axi_lite_mem_slave

- AXI4-Lite responder (slave) on the interconnect's slave port.
- Serves read and write transactions from the master against an internal byte-wide memory of `BUFFER_SIZE` locations.
- Uses the package widths (12-bit address, 8-bit data, 1-bit strobe), the package response codes and the `state_type` encoding.
- Handles one transaction at a time through a single FSM; its memory is the DUT-side counterpart of the scoreboard's reference buffer.

## Interface

Parameters:
- `ADDR_WIDTH`, 12, address width in bits.
- `DATA_WIDTH`, 8, data width in bits.
- `STRB_WIDTH`, `DATA_WIDTH/8` (1), write strobe width.
- `BUFFER_SIZE`, 4096, number of memory locations; addresses at or above it are out of range.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `ar_addr`  in  ADDR_WIDTH  read address.
- `ar_valid`  in  1  read address valid.
- `ar_ready`  out  1  read address accepted.
- `r_data`  out  DATA_WIDTH  read data.
- `r_resp`  out  2  read response.
- `r_valid`  out  1  read data valid.
- `r_ready`  in  1  master accepts read data.
- `aw_addr`  in  ADDR_WIDTH  write address.
- `aw_valid`  in  1  write address valid.
- `aw_ready`  out  1  write address accepted.
- `w_data`  in  DATA_WIDTH  write data.
- `w_strb`  in  STRB_WIDTH  byte-lane enable.
- `w_valid`  in  1  write data valid.
- `w_ready`  out  1  write data accepted.
- `b_resp`  out  2  write response.
- `b_valid`  out  1  write response valid.
- `b_ready`  in  1  master accepts response.

## Operation

The FSM uses the `state_type` encoding: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP.

- **IDLE:**
  - `ar_valid` → RADDR. Reads take priority when `ar_valid` and `aw_valid` are both high.
  - else `aw_valid` → WADDR.
  - else stay in IDLE.
- **RADDR:**
  - `ar_ready`=1 for exactly this cycle; `ar_addr` is latched.
  - `r_data` and `r_resp` are registered → RDATA.
- **RDATA:**
  - `r_valid`=1; `r_data` and `r_resp` are held stable.
  - On `r_valid && r_ready` → IDLE.
- **WADDR:**
  - `aw_ready`=1 for exactly this cycle; `aw_addr` is latched → WDATA.
- **WDATA:**
  - `w_ready`=1 until `w_valid` is seen.
  - On `w_valid && w_ready`: if the address is in range and `w_strb[0]`=1, write `mem[addr]` ← `w_data`.
  - Register `b_resp` → WRESP.
- **WRESP:**
  - `b_valid`=1; `b_resp` is held.
  - On `b_valid && b_ready` → IDLE.

Response and memory rules:
- Response is RESP_OKAY if the address < `BUFFER_SIZE`, else RESP_SLVERR.
  - Out-of-range read returns `r_data`=0.
  - Out-of-range write leaves memory unchanged.
- Strobe 0 is a legal write: memory is unchanged and the response is OKAY.
- Memory contents are not affected by reset.

## Timing

- All outputs are registered.
- Reset values: `ar_ready`, `r_valid`, `aw_ready`, `w_ready`, `b_valid` = 0; `r_data`=0; `r_resp`=`b_resp`=RESP_OKAY; state=IDLE.
- **Read timing:** `ar_valid` sampled in IDLE at edge N.
  - `ar_ready` high in cycle N+1.
  - `r_valid` high from cycle N+2.
  - Minimum 3 cycles from IDLE back to IDLE when `r_ready` is held high.
- **Write timing:** `aw_valid` sampled at edge N.
  - `aw_ready` high in cycle N+1.
  - `w_ready` high from cycle N+2.
  - `b_valid` high the cycle after the W handshake.
  - Minimum 4 cycles with `w_valid` and `b_ready` held high.
- The slave never drops a valid before its handshake. Master stalls (`r_ready`/`b_ready` low) hold the state indefinitely.
- `w_valid` may arrive before `aw_valid`; W is accepted only in WDATA.
- Simultaneous AR and AW in IDLE: the read is serviced first; AW is accepted in the next IDLE.
- A read issued in the cycle after a write to the same address returns the new data (memory write at the W handshake edge).
- Reset asserted mid-transaction:
  - All outputs are forced to their reset values immediately (asynchronously).
  - A write whose W handshake edge has not yet occurred is not committed.
  - On release, the FSM starts in IDLE.

## Test plan

- **Reset:** assert `areset_n`=0 mid-RDATA.
  - → `r_valid` drops immediately; all outputs take their reset values.
  - → after release, read 0x004 after write 0x004=0x5A returns 0x5A.
- **Write then read:** write 0x014=0xA5 (strb=1) → `b_resp`=00, `b_valid` 1 cycle after W; read 0x014 → `r_data`=0xA5, `r_resp`=00, `r_valid` 2 cycles after AR sampled.
- **Zero strobe:** write 0x014=0x33 with strb=0 → `b_resp`=00; read 0x014 returns the prior 0xA5.
- **Backpressure:** `r_ready` and `b_ready` held low 5 cycles.
  - → `r_valid`/`b_valid` and `r_data`/`b_resp` stay stable.
  - → complete on the first ready cycle.
- **Simultaneous AR and AW:** AR 0x004 and AW 0x004 (data 0x77) asserted in the same cycle.
  - → `ar_ready` pulses first and the read returns the old value.
  - → `aw_ready` follows after the R handshake.
  - → a later read returns 0x77.
- **Out of range:** with `BUFFER_SIZE`=2048, write 0x900=0x11 → `b_resp`=10; read 0x900 → `r_data`=0, `r_resp`=10; `mem[0x100]` untouched.
